// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM encoding, frame shape and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
  localparam logic        LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, clears on request, strobes the last and
// second-to-last cycle of each bit period.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end_c,
  output logic bit_pre_end_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end_c     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    bit_pre_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
    cnt_d         = (clr || bit_end_c) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO reader + UART 8N1 transmitter: pops one byte whenever idle and allowed,
// then serialises it LSB first on tx.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  input  logic                 fifo_push,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_pop,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("fifo_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (STOP_BITS != 1) begin : g_bad_stop
      $error("fifo_uart_tx: only one stop bit is supported");
    end
  endgenerate

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   clr_c, bit_end_c, pre_end_c;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk           (clk),
    .rst_n         (reset_n),
    .clr           (clr_c),
    .bit_end_c     (bit_end_c),
    .bit_pre_end_c (pre_end_c)
  );

  // The FIFO ignores pop on push cycles, so never request one then.
  assign fifo_pop = (state_q == IDLE) & tx_enable & ~fifo_empty & ~fifo_push & reset_n;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        if (fifo_pop) state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (bit_end_c) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            tx_d    = LINE_IDLE;
            state_d = STOP;
          end else begin
            tx_d  = shift_q[1];
            idx_d = idx_q + BIT_IDX_W'(1);
          end
        end
      end
      STOP: begin
        // Registered pulse lands on the final stop-bit cycle.
        done_d = pre_end_c;
        if (bit_end_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    clr_c  = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx against a cycle-timeline model of the frame.
module tb_fifo_uart_tx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int          CPB    = CLK_HZ / BAUD;
  localparam int          FRAME  = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset_n, tx_enable, fifo_empty, fifo_push;
  logic [7:0] fifo_data;
  logic       fifo_pop, tx, busy, frame_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_p = 0;
  logic [7:0] m_byte = '0;
  logic [7:0] exp_q[$];
  logic [7:0] fq[$];
  logic [7:0] push_byte;
  bit         pop_seen = 1'b0, push_seen = 1'b0;
  int         frames_seen = 0, frames_exp = 0;

  fifo_uart_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_push  (fifo_push),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: a frame occupies cycles P+1..P+1+FRAME after a pop in cycle P.
  always @(negedge clk) begin
    logic e_tx, e_pop, e_done;
    int   k, b;
    cyc++;
    if (!reset_n) m_active = 1'b0;
    else if (m_active && cyc > m_p + 1 + FRAME) m_active = 1'b0;
    e_tx   = 1'b1;
    e_done = 1'b0;
    if (m_active && cyc >= m_p + 2) begin
      k = cyc - m_p - 2;
      b = k / CPB;
      if (b == 0)      e_tx = 1'b0;
      else if (b <= 8) e_tx = m_byte[3'(b - 1)];
    end
    if (m_active && cyc == m_p + 1 + FRAME) e_done = 1'b1;
    e_pop = !m_active && tx_enable && !fifo_empty && !fifo_push && reset_n;
    check("tx", 32'(tx), 32'(e_tx));
    check("busy", 32'(busy), 32'(m_active));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("fifo_pop", 32'(fifo_pop), 32'(e_pop));
    if (e_done) frames_exp++;
    if (frame_done) frames_seen++;
    pop_seen  = fifo_pop;
    push_seen = fifo_push;
    if (e_pop) begin
      m_active = 1'b1;
      m_p      = cyc;
      m_byte   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    end
  end

  // One clock of the FIFO environment: commit push/pop seen in the last cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_seen && fq.size() > 0) fifo_data = fq.pop_front();
    else                           fifo_data = 8'($urandom);
    if (push_seen) begin
      fq.push_back(push_byte);
      exp_q.push_back(push_byte);
    end
    fifo_empty = (fq.size() == 0);
    fifo_push  = 1'b0;
  endtask

  task automatic push(input logic [7:0] val);
    fifo_push = 1'b1;
    push_byte = val;
    step();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_pop(input int bound);
    int i = 0;
    while (!m_active && i < bound) begin
      step();
      i++;
    end
    step();
    check("wait_pop_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_drain(input int bound);
    int i = 0;
    while ((m_active || fq.size() > 0) && i < bound) begin
      step();
      i++;
    end
    check("drain_fifo", 32'(fq.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    tx_enable  = 1'b0;
    fifo_empty = 1'b1;
    fifo_push  = 1'b0;
    fifo_data  = 8'h00;
    push_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    tx_enable = 1'b1;

    // Empty FIFO: line stays idle.
    run(1000);

    // Single byte.
    push(8'hA5);
    wait_drain(300);
    check("a5_frames", 32'(frames_seen), 32'd1);

    // Three bytes back to back.
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_drain(500);
    check("three_frames", 32'(frames_seen), 32'd4);

    // Push held over several cycles blocks pop.
    push(8'h5A);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_drain(600);

    // tx_enable dropped mid-frame.
    push(8'hC3);
    push(8'h96);
    wait_pop(20);
    run(38);
    tx_enable = 1'b0;
    run(FRAME + 50);
    check("txen_hold_fifo", 32'(fq.size()), 32'd1);
    tx_enable = 1'b1;
    #1;
    check("reenable_pop", 32'(fifo_pop), 32'd1);
    wait_drain(300);

    // Reset mid-frame, then a clean frame.
    push(8'h69);
    wait_pop(20);
    run(53);
    reset_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    run(3);
    reset_n = 1'b1;
    push(8'hE7);
    wait_drain(300);

    // Random traffic with occasional enable toggles.
    repeat (3000) begin
      if ($urandom_range(0, 11) == 0 && fq.size() < 6) begin
        fifo_push = 1'b1;
        push_byte = 8'($urandom);
      end
      if ($urandom_range(0, 199) == 0) tx_enable = ~tx_enable;
      step();
    end
    tx_enable = 1'b1;
    wait_drain(2000);

    check("frame_count", 32'(frames_seen), 32'(frames_exp));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
